// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, coordinate type and width helpers used by all
// display blocks.
package vga_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    function automatic int line_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOTAL_DEF = line_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL_DEF = line_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

    // Width of a packed {R,G,B} tuple.
    function automatic int color_tuple_w(input int color_w);
        return 3 * color_w;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-enable driven h/v raster counters with active-region flag and
// active-low sync decode; syncs are combinational from the counters.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   pix_en_i,
    output coord_t h_o,
    output coord_t v_o,
    output logic   active_o,
    output logic   hsync_n_o,
    output logic   vsync_n_o,
    output logic   frame_end_o
);

    localparam int     H_TOTAL  = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int     V_TOTAL  = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    coord_t h_q, h_d;
    coord_t v_q, v_d;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_en_i) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_o         = h_q;
    assign v_o         = v_q;
    assign active_o    = (h_q < coord_t'(H_ACTIVE)) && (v_q < coord_t'(V_ACTIVE));
    assign hsync_n_o   = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
    assign vsync_n_o   = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
    // Last pixel of the frame is being consumed this cycle.
    assign frame_end_o = pix_en_i && (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: rtl/vga_sprite_engine.sv
// VGA sprite overlay: double-buffered sprite registers swapped at frame end,
// lowest-index priority hit selection and a one-pixel registered output stage.
module vga_sprite_engine
    import vga_pkg::*;
#(
    parameter int N_SPRITES   = 4,
    parameter int SPRITE_SIZE = 8,
    parameter int COLOR_W     = 4,
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int H_FP        = H_FP_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BP        = H_BP_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int V_FP        = V_FP_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BP        = V_BP_DEF,
    localparam int IDX_W      = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1,
    localparam int CT_W       = color_tuple_w(COLOR_W)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               pix_en_i,
    // A write transfers on a cycle where wr_valid_i && wr_ready_o; the master
    // holds all wr_* fields stable while wr_valid_i is high and not yet accepted.
    input  logic               wr_valid_i,
    output logic               wr_ready_o,
    input  logic [IDX_W-1:0]   wr_idx_i,
    input  coord_t             wr_x_i,
    input  coord_t             wr_y_i,
    input  logic               wr_en_i,
    input  logic [CT_W-1:0]    wr_color_i,
    input  logic [CT_W-1:0]    bg_color_i,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic [COLOR_W-1:0] red_o,
    output logic [COLOR_W-1:0] green_o,
    output logic [COLOR_W-1:0] blue_o,
    output logic               frame_start_o
);

    localparam logic [COORD_W:0] SIZE_EXT = (COORD_W + 1)'(SPRITE_SIZE);

    coord_t h, v;
    logic   active, hsync_n, vsync_n, commit;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .pix_en_i    (pix_en_i),
        .h_o         (h),
        .v_o         (v),
        .active_o    (active),
        .hsync_n_o   (hsync_n),
        .vsync_n_o   (vsync_n),
        .frame_end_o (commit)
    );

    coord_t            pend_x_q [N_SPRITES], pend_x_d [N_SPRITES];
    coord_t            pend_y_q [N_SPRITES], pend_y_d [N_SPRITES];
    logic              pend_en_q[N_SPRITES], pend_en_d[N_SPRITES];
    logic [CT_W-1:0]   pend_c_q [N_SPRITES], pend_c_d [N_SPRITES];
    coord_t            act_x_q  [N_SPRITES], act_x_d  [N_SPRITES];
    coord_t            act_y_q  [N_SPRITES], act_y_d  [N_SPRITES];
    logic              act_en_q [N_SPRITES], act_en_d [N_SPRITES];
    logic [CT_W-1:0]   act_c_q  [N_SPRITES], act_c_d  [N_SPRITES];

    logic              ready_q;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic [CT_W-1:0]   rgb_q, rgb_d;
    logic              fs_q, fs_d;

    logic              wr_fire, idx_ok;
    logic [N_SPRITES-1:0] hit;
    logic [CT_W-1:0]   pix_color;

    // Holding ready low during the swap keeps a write from landing half in
    // the old frame's pending set and half in the new active set.
    assign wr_ready_o = ready_q && !commit;
    assign wr_fire    = wr_valid_i && wr_ready_o;
    assign idx_ok     = int'(wr_idx_i) < N_SPRITES;

    // 11-bit compares so a sprite starting near 1023 cannot wrap onto column/row 0.
    for (genvar i = 0; i < N_SPRITES; i++) begin : g_hit
        assign hit[i] = act_en_q[i]
                     && ({1'b0, h} >= {1'b0, act_x_q[i]})
                     && ({1'b0, h} <  ({1'b0, act_x_q[i]} + SIZE_EXT))
                     && ({1'b0, v} >= {1'b0, act_y_q[i]})
                     && ({1'b0, v} <  ({1'b0, act_y_q[i]} + SIZE_EXT));
    end

    always_comb begin
        pix_color = bg_color_i;
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if (hit[i]) pix_color = act_c_q[i];
        end
    end

    always_comb begin
        pend_x_d  = pend_x_q;
        pend_y_d  = pend_y_q;
        pend_en_d = pend_en_q;
        pend_c_d  = pend_c_q;
        act_x_d   = act_x_q;
        act_y_d   = act_y_q;
        act_en_d  = act_en_q;
        act_c_d   = act_c_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        rgb_d     = rgb_q;
        fs_d      = pix_en_i && (h == '0) && (v == '0);
        if (pix_en_i) begin
            hsync_d = hsync_n;
            vsync_d = vsync_n;
            rgb_d   = active ? pix_color : '0;
        end
        if (commit) begin
            act_x_d  = pend_x_q;
            act_y_d  = pend_y_q;
            act_en_d = pend_en_q;
            act_c_d  = pend_c_q;
        end
        if (wr_fire && idx_ok) begin
            pend_x_d[wr_idx_i]  = wr_x_i;
            pend_y_d[wr_idx_i]  = wr_y_i;
            pend_en_d[wr_idx_i] = wr_en_i;
            pend_c_d[wr_idx_i]  = wr_color_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_q <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= '0;
            fs_q    <= 1'b0;
            for (int i = 0; i < N_SPRITES; i++) begin
                pend_x_q[i]  <= '0;
                pend_y_q[i]  <= '0;
                pend_en_q[i] <= 1'b0;
                pend_c_q[i]  <= '0;
                act_x_q[i]   <= '0;
                act_y_q[i]   <= '0;
                act_en_q[i]  <= 1'b0;
                act_c_q[i]   <= '0;
            end
        end else begin
            ready_q   <= 1'b1;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            rgb_q     <= rgb_d;
            fs_q      <= fs_d;
            pend_x_q  <= pend_x_d;
            pend_y_q  <= pend_y_d;
            pend_en_q <= pend_en_d;
            pend_c_q  <= pend_c_d;
            act_x_q   <= act_x_d;
            act_y_q   <= act_y_d;
            act_en_q  <= act_en_d;
            act_c_q   <= act_c_d;
        end
    end

    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign red_o         = rgb_q[CT_W-1 -: COLOR_W];
    assign green_o       = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign blue_o        = rgb_q[COLOR_W-1:0];
    assign frame_start_o = fs_q;

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Randomized bench for vga_sprite_engine on a shrunken raster, checked every
// clock against a frame-level reference model of the sprite display.
module tb_vga_sprite_engine;

    localparam int N   = 3;
    localparam int SS  = 8;
    localparam int CW  = 4;
    localparam int CT  = 3 * CW;
    localparam int OW  = CT + 3;
    localparam int HA  = 40, HFP = 4, HS = 6, HBP = 5;
    localparam int VA  = 30, VFP = 2, VS = 2, VBP = 3;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    logic          clk = 1'b0;
    logic          rst;
    logic          pix_en;
    logic          wr_valid;
    logic          wr_ready;
    logic [1:0]    wr_idx;
    logic [9:0]    wr_x, wr_y;
    logic          wr_en;
    logic [CT-1:0] wr_color, bg_color;
    logic          hsync, vsync, frame_start;
    logic [CW-1:0] red, green, blue;

    vga_sprite_engine #(
        .N_SPRITES(N), .SPRITE_SIZE(SS), .COLOR_W(CW),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .pix_en_i     (pix_en),
        .wr_valid_i   (wr_valid),
        .wr_ready_o   (wr_ready),
        .wr_idx_i     (wr_idx),
        .wr_x_i       (wr_x),
        .wr_y_i       (wr_y),
        .wr_en_i      (wr_en),
        .wr_color_i   (wr_color),
        .bg_color_i   (bg_color),
        .hsync_o      (hsync),
        .vsync_o      (vsync),
        .red_o        (red),
        .green_o      (green),
        .blue_o       (blue),
        .frame_start_o(frame_start)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard and reference model state
    logic [OW-1:0] exp_q[$];
    int            errors = 0;
    int            checks = 0;
    int            mh, mv;
    bit            m_rdy;
    logic [OW-1:0] m_out;
    int            px[16], py[16], ax[16], ay[16];
    bit            pen[16], aen[16];
    logic [CT-1:0] pc[16], ac[16];
    int            pix_mode;
    bit            last_fire, last_ready;
    int            ready_lo;
    localparam logic [OW-1:0] RESET_WORD = {1'b0, 1'b1, 1'b1, {CT{1'b0}}};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [CT-1:0] model_pixel(input int h, input int v);
        if (h >= HA || v >= VA) return '0;
        for (int i = 0; i < N; i++) begin
            if (aen[i] && h >= ax[i] && h < ax[i] + SS && v >= ay[i] && v < ay[i] + SS)
                return ac[i];
        end
        return bg_color;
    endfunction

    function automatic bit model_ready();
        return m_rdy && !(pix_en && mh == HT - 1 && mv == VT - 1);
    endfunction

    task automatic model_reset();
        mh = 0; mv = 0; m_rdy = 0;
        m_out = RESET_WORD;
        for (int i = 0; i < 16; i++) begin
            px[i] = 0; py[i] = 0; pen[i] = 0; pc[i] = '0;
            ax[i] = 0; ay[i] = 0; aen[i] = 0; ac[i] = '0;
        end
        exp_q.delete();
    endtask

    // One clock of the display as seen from outside: pixel emitted, frame
    // swap of the sprite table, then any accepted write lands in pending.
    task automatic model_step();
        bit commit;
        commit    = pix_en && mh == HT - 1 && mv == VT - 1;
        last_fire = wr_valid && m_rdy && !commit;
        m_out[OW-1] = pix_en && mh == 0 && mv == 0;
        if (pix_en) begin
            m_out[OW-2]   = !(mh >= HA + HFP && mh < HA + HFP + HS);
            m_out[OW-3]   = !(mv >= VA + VFP && mv < VA + VFP + VS);
            m_out[CT-1:0] = model_pixel(mh, mv);
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv = (mv + 1) % VT;
            end
        end
        if (commit) begin
            for (int i = 0; i < 16; i++) begin
                ax[i] = px[i]; ay[i] = py[i]; aen[i] = pen[i]; ac[i] = pc[i];
            end
        end
        if (last_fire && int'(wr_idx) < N) begin
            px[wr_idx] = int'(wr_x); py[wr_idx] = int'(wr_y);
            pen[wr_idx] = wr_en; pc[wr_idx] = wr_color;
        end
        m_rdy = 1;
        exp_q.push_back(m_out);
    endtask

    // driver tasks (entered and left on a falling edge)
    task automatic tick();
        logic [OW-1:0] exp;
        case (pix_mode)
            0:       pix_en = 1'b1;
            1:       pix_en = !pix_en;
            default: pix_en = ($urandom_range(0, 3) != 0);
        endcase
        #1;
        check("wr_ready", 32'(wr_ready), 32'(model_ready()));
        last_ready = wr_ready;
        @(posedge clk);
        model_step();
        @(negedge clk);
        exp = exp_q.pop_front();
        check("pixel", 32'({frame_start, hsync, vsync, red, green, blue}), 32'(exp));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic run_to(input int h, input int v);
        int n;
        n = 0;
        while (!(mh == h && mv == v) && n < 4 * FRAME) begin
            tick();
            n++;
        end
        check("run_to_bound", 32'(n < 4 * FRAME), 32'd1);
    endtask

    task automatic write_sprite(input logic [1:0] idx, input int x, input int y,
                                input logic en, input logic [CT-1:0] c);
        int n;
        wr_idx = idx; wr_x = 10'(x); wr_y = 10'(y); wr_en = en; wr_color = c;
        wr_valid = 1'b1;
        n = 0;
        ready_lo = 0;
        do begin
            tick();
            if (!last_ready) ready_lo++;
            n++;
        end while (!last_fire && n < 16);
        wr_valid = 1'b0;
        check("wr_accept", 32'(last_fire), 32'd1);
    endtask

    task automatic do_reset();
        wr_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("rst_async_out", 32'({frame_start, hsync, vsync, red, green, blue}), 32'(RESET_WORD));
        check("rst_async_rdy", 32'(wr_ready), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_out", 32'({frame_start, hsync, vsync, red, green, blue}), 32'(RESET_WORD));
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b0; wr_valid = 1'b0; wr_idx = '0;
        wr_x = '0; wr_y = '0; wr_en = 1'b0; wr_color = '0;
        bg_color = CT'($urandom_range(0, (1 << CT) - 1));
        pix_mode = 0;
        model_reset();
        #1;
        check("rst_init_out", 32'({frame_start, hsync, vsync, red, green, blue}), 32'(RESET_WORD));
        check("rst_init_rdy", 32'(wr_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // idle raster: syncs, background and blanking over a full frame
        run(FRAME + 5);

        // mid-frame write becomes visible only from the next frame
        run_to(20, 10);
        write_sprite(2'd0, 10, 5, 1'b1, 12'hF00);
        run(FRAME + 50);

        // overlap: lower index wins
        write_sprite(2'd1, 13, 8, 1'b1, 12'h0F0);
        run(FRAME + 10);

        // clipped at right edge, near-1023 positions, out-of-range index discarded
        write_sprite(2'd2, HA - 4, 20, 1'b1, 12'h00F);
        write_sprite(2'd1, 1020, 2, 1'b1, 12'h0FF);
        write_sprite(2'd0, 5, 1020, 1'b1, 12'hF0F);
        write_sprite(2'd3, 0, 0, 1'b1, 12'hFFF);
        run(2 * FRAME);

        // write presented exactly on the frame-swap cycle
        run_to(HT - 1, VT - 1);
        write_sprite(2'd1, 30, 2, 1'b1, 12'h0F0);
        check("commit_stall", 32'(ready_lo), 32'd1);
        run(2 * FRAME);

        // random pixel enable and random sprite writes
        pix_mode = 2;
        for (int k = 0; k < 3 * FRAME; k++) begin
            if ($urandom_range(0, 150) == 0) begin
                write_sprite(2'($urandom_range(0, 3)),
                             ($urandom_range(0, 3) == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, HA + 4),
                             ($urandom_range(0, 3) == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, VA + 4),
                             1'($urandom_range(0, 1)), CT'($urandom_range(0, (1 << CT) - 1)));
            end else begin
                tick();
            end
        end

        // half-rate pixel enable with a reset in the middle of a frame
        pix_mode = 1;
        write_sprite(2'd0, 2, 3, 1'b1, 12'hF00);
        run(2 * FRAME);
        run_to(20, 15);
        do_reset();
        write_sprite(2'd2, 6, 1, 1'b1, 12'h5A5);
        run(4 * FRAME + 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
